// File: rtl/pcs_rx_sync_pkg.sv
// Shared 1000BASE-X PCS code-group constants and the one-hot receive-sync state set.
// The state encoding lives here so the PCS receive FSM can decode sync state directly.
package pcs_rx_sync_pkg;

    // Special (K) code-groups, running-disparity-negative form; RD+ is the bitwise complement.
    localparam logic [9:0] SPECIAL_CODE_K28_0_10B = 10'b0011110100;
    localparam logic [9:0] SPECIAL_CODE_K28_1_10B = 10'b0011111001;
    localparam logic [9:0] SPECIAL_CODE_K28_2_10B = 10'b0011110101;
    localparam logic [9:0] SPECIAL_CODE_K28_3_10B = 10'b0011110011;
    localparam logic [9:0] SPECIAL_CODE_K28_4_10B = 10'b0011110010;
    localparam logic [9:0] SPECIAL_CODE_K28_5_10B = 10'b0011111010;
    localparam logic [9:0] SPECIAL_CODE_K28_6_10B = 10'b0011110110;
    localparam logic [9:0] SPECIAL_CODE_K28_7_10B = 10'b0011111000;
    localparam logic [9:0] SPECIAL_CODE_K23_7_10B = 10'b1110101000;
    localparam logic [9:0] SPECIAL_CODE_K27_7_10B = 10'b1101101000;
    localparam logic [9:0] SPECIAL_CODE_K29_7_10B = 10'b1011101000;
    localparam logic [9:0] SPECIAL_CODE_K30_7_10B = 10'b0111101000;

    localparam int unsigned SPECIAL_CODE_NUM = 12;
    localparam logic [9:0] SPECIAL_CODES_10B [SPECIAL_CODE_NUM] = '{
        SPECIAL_CODE_K28_0_10B, SPECIAL_CODE_K28_1_10B, SPECIAL_CODE_K28_2_10B,
        SPECIAL_CODE_K28_3_10B, SPECIAL_CODE_K28_4_10B, SPECIAL_CODE_K28_5_10B,
        SPECIAL_CODE_K28_6_10B, SPECIAL_CODE_K28_7_10B, SPECIAL_CODE_K23_7_10B,
        SPECIAL_CODE_K27_7_10B, SPECIAL_CODE_K29_7_10B, SPECIAL_CODE_K30_7_10B
    };

    localparam int unsigned SYNC_STATE_NUM = 13;

    typedef enum logic [SYNC_STATE_NUM-1:0] {
        LOSS_OF_SYNC     = 13'h0001,
        COMMA_DETECT_1   = 13'h0002,
        ACQUIRE_SYNC_1   = 13'h0004,
        COMMA_DETECT_2   = 13'h0008,
        ACQUIRE_SYNC_2   = 13'h0010,
        COMMA_DETECT_3   = 13'h0020,
        SYNC_ACQUIRED_1  = 13'h0040,
        SYNC_ACQUIRED_2  = 13'h0080,
        SYNC_ACQUIRED_2A = 13'h0100,
        SYNC_ACQUIRED_3  = 13'h0200,
        SYNC_ACQUIRED_3A = 13'h0400,
        SYNC_ACQUIRED_4  = 13'h0800,
        SYNC_ACQUIRED_4A = 13'h1000
    } sync_state_t;

    function automatic logic is_special_code(input logic [9:0] cg);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < SPECIAL_CODE_NUM; i++) begin
            if (cg == SPECIAL_CODES_10B[i] || cg == ~SPECIAL_CODES_10B[i]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/pcs_rx_sync_if.sv
// Code-group stream into the receive-sync block and the qualified stream out of it.
interface pcs_rx_sync_if;
    logic [9:0] PUDR;
    logic       signal_detect;
    logic [9:0] SUDI;
    logic       rx_even;
    logic       code_sync_status;

    modport master (output PUDR, output signal_detect,
                    input  SUDI, input  rx_even, input code_sync_status);
    modport slave  (input  PUDR, input  signal_detect,
                    output SUDI, output rx_even, output code_sync_status);
endinterface

// File: rtl/pcs_rx_sync_cg_check.sv
// Combinational code-group classifier: comma pattern, invalid code-group, data code-group.
module pcs_rx_sync_cg_check
    import pcs_rx_sync_pkg::*;
(
    input  logic [9:0] cg,
    output logic       comma,
    output logic       invalid,
    output logic       is_data
);

    assign comma = (cg[9:3] == 7'b0011111) || (cg[9:3] == 7'b1100000);

    // Unbalanced weight or a run of six/four identical bits cannot be a legal 8b/10b symbol.
    assign invalid = ($countones(cg) < 4) || ($countones(cg) > 6)
                   || (cg[9:4] == 6'b000000) || (cg[9:4] == 6'b111111)
                   || (cg[3:0] == 4'b0000)   || (cg[3:0] == 4'b1111);

    assign is_data = !invalid && !is_special_code(cg);

endmodule

// File: rtl/pcs_rx_sync.sv
// 1000BASE-X PCS receive synchronization: comma alignment, code-group qualification, sync status.
// Optional macro PCS_SYNC_LOSS_CNT_EN adds a saturating loss-of-sync event counter port.
module pcs_rx_sync
    import pcs_rx_sync_pkg::*;
#(
    parameter int GOOD_CGS_MAX = 3
`ifdef PCS_SYNC_LOSS_CNT_EN
    , parameter int LOSS_CNT_W = 8
`endif
) (
    input  logic         GTX_CLK,
    input  logic         mr_main_reset,
    pcs_rx_sync_if.slave rx
`ifdef PCS_SYNC_LOSS_CNT_EN
    , output logic [LOSS_CNT_W-1:0] loss_cnt
`endif
);

    sync_state_t state, next_state;
    logic [1:0]  good_cgs, good_cgs_nxt;
    logic        comma, invalid, is_data;
    logic        cgbad, comma_ok, max_good, rx_even_nxt, status_nxt;

    pcs_rx_sync_cg_check u_cg_check (
        .cg      (rx.PUDR),
        .comma   (comma),
        .invalid (invalid),
        .is_data (is_data)
    );

    assign cgbad    = invalid || (comma && rx.rx_even);
    assign comma_ok = comma && !invalid;
    assign max_good = (good_cgs == 2'(GOOD_CGS_MAX));

    always_comb begin
        next_state = state;
        case (state)
            LOSS_OF_SYNC:     if (comma_ok) next_state = COMMA_DETECT_1;
            COMMA_DETECT_1:   next_state = is_data ? ACQUIRE_SYNC_1 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_1:   if (cgbad) next_state = LOSS_OF_SYNC;
                              else if (comma && !rx.rx_even) next_state = COMMA_DETECT_2;
            COMMA_DETECT_2:   next_state = is_data ? ACQUIRE_SYNC_2 : LOSS_OF_SYNC;
            ACQUIRE_SYNC_2:   if (cgbad) next_state = LOSS_OF_SYNC;
                              else if (comma && !rx.rx_even) next_state = COMMA_DETECT_3;
            COMMA_DETECT_3:   next_state = is_data ? SYNC_ACQUIRED_1 : LOSS_OF_SYNC;
            SYNC_ACQUIRED_1:  if (cgbad) next_state = SYNC_ACQUIRED_2;
            SYNC_ACQUIRED_2:  next_state = cgbad ? SYNC_ACQUIRED_3 : SYNC_ACQUIRED_2A;
            SYNC_ACQUIRED_2A: if (cgbad) next_state = SYNC_ACQUIRED_3;
                              else if (max_good) next_state = SYNC_ACQUIRED_1;
            SYNC_ACQUIRED_3:  next_state = cgbad ? SYNC_ACQUIRED_4 : SYNC_ACQUIRED_3A;
            SYNC_ACQUIRED_3A: if (cgbad) next_state = SYNC_ACQUIRED_4;
                              else if (max_good) next_state = SYNC_ACQUIRED_2;
            SYNC_ACQUIRED_4:  next_state = cgbad ? LOSS_OF_SYNC : SYNC_ACQUIRED_4A;
            SYNC_ACQUIRED_4A: if (cgbad) next_state = LOSS_OF_SYNC;
                              else if (max_good) next_state = SYNC_ACQUIRED_3;
            default:          next_state = LOSS_OF_SYNC;
        endcase
        if (!rx.signal_detect) next_state = LOSS_OF_SYNC;
    end

    // Outputs describe the state being entered so they line up with the word landing in SUDI.
    always_comb begin
        good_cgs_nxt = good_cgs;
        rx_even_nxt  = !rx.rx_even;
        status_nxt   = 1'b0;
        if (next_state inside {COMMA_DETECT_1, COMMA_DETECT_2, COMMA_DETECT_3})
            rx_even_nxt = 1'b1;
        if (next_state inside {SYNC_ACQUIRED_1, SYNC_ACQUIRED_2, SYNC_ACQUIRED_2A,
                               SYNC_ACQUIRED_3, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4,
                               SYNC_ACQUIRED_4A})
            status_nxt = 1'b1;
        if (next_state inside {SYNC_ACQUIRED_2, SYNC_ACQUIRED_3, SYNC_ACQUIRED_4})
            good_cgs_nxt = 2'd0;
        else if (next_state inside {SYNC_ACQUIRED_2A, SYNC_ACQUIRED_3A, SYNC_ACQUIRED_4A})
            good_cgs_nxt = good_cgs + 2'd1;
    end

    always_ff @(posedge GTX_CLK) begin
        if (!mr_main_reset) begin
            state               <= LOSS_OF_SYNC;
            good_cgs            <= 2'd0;
            rx.SUDI             <= 10'd0;
            rx.rx_even          <= 1'b0;
            rx.code_sync_status <= 1'b0;
        end else begin
            state               <= next_state;
            good_cgs            <= good_cgs_nxt;
            rx.SUDI             <= rx.PUDR;
            rx.rx_even          <= rx_even_nxt;
            rx.code_sync_status <= status_nxt;
        end
    end

`ifdef PCS_SYNC_LOSS_CNT_EN
    // code_sync_status is high exactly while in a SYNC_ACQUIRED_* state.
    always_ff @(posedge GTX_CLK) begin
        if (!mr_main_reset) begin
            loss_cnt <= '0;
        end else if (rx.code_sync_status && next_state == LOSS_OF_SYNC && loss_cnt != '1) begin
            loss_cnt <= loss_cnt + 1'b1;
        end
    end
`endif

endmodule
